// File: rtl/tx_sched_pkg.sv
// Shared constants for the TX byte-slot scheduler.
//   COM_SYMBOL : idle / sync symbol sent whenever a slot carries no data
//   SLOT_LAST  : last bit position of an 8-cycle byte slot
//   ST_SYNC / ST_ARB : scheduler FSM encoding
package tx_sched_pkg;

    localparam logic [7:0] COM_SYMBOL = 8'hBC;
    localparam logic [2:0] SLOT_LAST  = 3'd7;

    localparam logic [0:0] ST_SYNC = 1'b0;
    localparam logic [0:0] ST_ARB  = 1'b1;

endpackage

// File: rtl/tx_byte_scheduler_rr_arbiter.sv
// rr_arbiter: purely combinational round-robin grant.
//   req        : request vector, one bit per source
//   last_grant : index of the most recently served source
//   grant      : one-hot grant (zero when nothing requests)
//   grant_idx  : binary index of the granted source
//   any_grant  : at least one source requested
// The search starts at last_grant+1 and wraps modulo NUM_REQ, so the
// source just served has the lowest priority in the next round.
module rr_arbiter #(
    parameter  int NUM_REQ = 2,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               any_grant
);

    // (base + off) mod NUM_REQ; off never exceeds NUM_REQ, so one
    // conditional subtract is enough and works for non-power-of-2 sizes.
    function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base,
                                                  input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return IDX_W'(s);
    endfunction

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!any_grant && req[wrap_idx(last_grant, k)]) begin
                grant[wrap_idx(last_grant, k)] = 1'b1;
                grant_idx = wrap_idx(last_grant, k);
                any_grant = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tx_byte_scheduler.sv
// tx_byte_scheduler: byte-slot scheduler in front of the TX serializer.
// Divides clk_32f into 8-cycle slots, sends SYNC_SYMBOLS COM slots after
// reset, then serves NUM_REQ byte sources round-robin, one byte per slot.
// Optional feature macro: TX_SCHED_SKIP_EN (forced COM skip slot after
// every SKIP_INTERVAL data bytes).
//
// Ports:
//   clk_32f    in   bit clock, 8 cycles per byte slot
//   reset_L    in   asynchronous active-low reset
//   req_valid  in   [NUM_REQ]   source i has a byte pending
//   req_data   in   [8*NUM_REQ] byte of source i at [8i+7:8i]
//   req_ready  out  [NUM_REQ]   one-hot grant, only in the last slot cycle
//   byte_out   out  [8]  byte for the serializer, held for a whole slot
//   byte_valid out       byte_out is data (0 = serializer sends COM)
//   slot_start out       first cycle of a slot
//   active     out       preamble done, arbitration running
//   fsm_state  out       current FSM state (ST_SYNC / ST_ARB), debug view
//
// Handshake: a byte moves from source i when req_valid[i] && req_ready[i]
// at a rising edge of clk_32f. Sources hold req_valid/req_data stable
// until accepted; req_valid must never depend on req_ready, while
// req_ready is a combinational function of req_valid in the slot's last
// cycle (a source raising valid in that cycle is still eligible).
module tx_byte_scheduler
    import tx_sched_pkg::*;
#(
    parameter int NUM_REQ       = 2,
    parameter int SYNC_SYMBOLS  = 4,
    parameter int SKIP_INTERVAL = 16
) (
    input  logic                 clk_32f,
    input  logic                 reset_L,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [7:0]           byte_out,
    output logic                 byte_valid,
    output logic                 slot_start,
    output logic                 active,
    output logic [0:0]           fsm_state
);

    localparam int IDX_W = $clog2(NUM_REQ);

    logic [2:0]       slot_cnt;
    logic [0:0]       state;
    logic [3:0]       sync_cnt;
    logic [IDX_W-1:0] last_grant;

    logic [NUM_REQ-1:0] arb_grant;
    logic [IDX_W-1:0]   arb_idx;
    logic               arb_any;
    logic               slot_end;
    logic               skip_slot;
    logic               grant_en;
    logic [7:0]         sel_byte;

    assign slot_end = (slot_cnt == SLOT_LAST);

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req        (req_valid),
        .last_grant (last_grant),
        .grant      (arb_grant),
        .grant_idx  (arb_idx),
        .any_grant  (arb_any)
    );

    assign grant_en  = (state == ST_ARB) && slot_end && !skip_slot;
    assign req_ready = grant_en ? arb_grant : '0;

`ifdef TX_SCHED_SKIP_EN
    // Counts data bytes since the last skip slot; once it reaches
    // SKIP_INTERVAL the following slot is forced to COM and the count
    // restarts. The round-robin pointer is untouched by a skip.
    logic [7:0] data_cnt;

    assign skip_slot = (data_cnt == 8'(SKIP_INTERVAL));

    always_ff @(posedge clk_32f or negedge reset_L) begin
        if (!reset_L) begin
            data_cnt <= 8'd0;
        end else if (state == ST_ARB && slot_end) begin
            if (skip_slot)
                data_cnt <= 8'd0;
            else if (arb_any)
                data_cnt <= data_cnt + 8'd1;
        end
    end
`else
    assign skip_slot = 1'b0;
    logic [7:0] unused_skip_interval;
    assign unused_skip_interval = 8'(SKIP_INTERVAL);
`endif

    // Byte of the granted source.
    always_comb begin
        sel_byte = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (IDX_W'(i) == arb_idx) sel_byte = req_data[8*i +: 8];
        end
    end

    always_ff @(posedge clk_32f or negedge reset_L) begin
        if (!reset_L) begin
            slot_cnt   <= 3'd0;
            state      <= ST_SYNC;
            sync_cnt   <= 4'd0;
            last_grant <= IDX_W'(NUM_REQ - 1);
            byte_out   <= COM_SYMBOL;
            byte_valid <= 1'b0;
        end else begin
            slot_cnt <= slot_cnt + 3'd1;
            // Everything that changes the presented byte happens on the
            // edge that closes a slot, so byte_out holds for 8 cycles.
            if (slot_end) begin
                if (state == ST_SYNC) begin
                    byte_out   <= COM_SYMBOL;
                    byte_valid <= 1'b0;
                    if (sync_cnt == 4'(SYNC_SYMBOLS - 1))
                        state <= ST_ARB;
                    else
                        sync_cnt <= sync_cnt + 4'd1;
                end else if (grant_en && arb_any) begin
                    byte_out   <= sel_byte;
                    byte_valid <= 1'b1;
                    last_grant <= arb_idx;
                end else begin
                    byte_out   <= COM_SYMBOL;
                    byte_valid <= 1'b0;
                end
            end
        end
    end

    assign slot_start = (slot_cnt == 3'd0);
    assign active     = (state == ST_ARB);
    assign fsm_state  = state;

endmodule
